// File: rtl/uart_pkg.sv
// Shared UART definitions for the loopback block.
//   uart_state_e : frame state, used by both the receiver and the transmitter
//   FRAME_BITS   : bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS    : data bits per frame
//   baud_div()   : clock cycles per bit, integer truncation
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  function automatic int baud_div(input int clk_frequency, input int baud);
    return clk_frequency / baud;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serializer with a byte load / busy handshake.
// Ports:
//   clk_12mhz : system clock, rising edge
//   reset_n   : synchronous active-low reset
//   load      : accept `data` and start a frame (only honoured while !busy)
//   data      : byte to send, LSB first
//   busy      : a frame is in progress
//   txd       : serial output, idle high
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | line high, waiting for load
// START | driving the start bit (0) for DIV cycles
// DATA  | driving data bits LSB first, DIV cycles each
// STOP  | driving the stop bit (1) for DIV cycles
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          txd_nxt;
  logic          tc;

  assign tc   = (cnt == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      bit_cnt <= bit_cnt_nxt;
      txd     <= txd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_nxt      = sh;
    bit_cnt_nxt = bit_cnt;
    txd_nxt     = txd;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = START;
          cnt_nxt   = DIV_M1;
          sh_nxt    = data;
          txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (tc) begin
          state_nxt   = DATA;
          cnt_nxt     = DIV_M1;
          txd_nxt     = sh[0];
          sh_nxt      = {1'b0, sh[7:1]};
          bit_cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (tc) begin
          cnt_nxt = DIV_M1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            txd_nxt     = sh[0];
            sh_nxt      = {1'b0, sh[7:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (tc) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_loopback.sv
// UART echo block: receives 8N1 bytes on rxd, retransmits each correctly
// framed byte on txd and shows the last one on the board LEDs.
// Ports:
//   clk_12mhz : system clock, rising edge
//   reset_n   : synchronous active-low reset
//   rxd       : serial input, idle high
//   txd       : serial output, idle high
//   led       : last correctly framed received byte
// Build option:
//   RX_SYNC_EN defined   -> rxd passes through a 2-flop synchronizer
//   RX_SYNC_EN undefined -> rxd sampled directly (synchronous stimulus only)
//
// Receiver:
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a low level on the (synchronized) line
// START | HALF cycles to mid start bit; high there means glitch
// DATA  | 8 mid-bit samples, DIV cycles apart, shifted in LSB first
// STOP  | one sample DIV later; high gives rx_valid, low is discarded
module uart_loopback
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 12_000_000,
  parameter int BAUD          = 115_200
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] led
);

  localparam int DIV  = baud_div(CLK_FREQUENCY, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rxd_s;

`ifdef RX_SYNC_EN
  logic [1:0] rxd_sync;

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      rxd_sync <= 2'b11;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
    end
  end

  assign rxd_s = rxd_sync[1];
`else
  assign rxd_s = rxd;
`endif

  uart_state_e rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt, rx_cnt_nxt;
  logic [7:0]    rx_sh, rx_sh_nxt;
  logic [2:0]    rx_bits, rx_bits_nxt;
  logic          rx_valid, rx_valid_nxt;
  logic          rx_tc;

  assign rx_tc = (rx_cnt == '0);

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bits  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_sh    <= rx_sh_nxt;
      rx_bits  <= rx_bits_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_sh_nxt    = rx_sh;
    rx_bits_nxt  = rx_bits;
    rx_valid_nxt = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rxd_s) begin
          rx_state_nxt = START;
          rx_cnt_nxt   = HALF_M1;
        end
      end
      START: begin
        if (rx_tc) begin
          if (!rxd_s) begin
            rx_state_nxt = DATA;
            rx_cnt_nxt   = DIV_M1;
            rx_bits_nxt  = '0;
          end else begin
            rx_state_nxt = IDLE;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      DATA: begin
        if (rx_tc) begin
          rx_sh_nxt  = {rxd_s, rx_sh[7:1]};
          rx_cnt_nxt = DIV_M1;
          if (rx_bits == LAST_BIT) begin
            rx_state_nxt = STOP;
          end else begin
            rx_bits_nxt = rx_bits + 1'b1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      STOP: begin
        if (rx_tc) begin
          rx_state_nxt = IDLE;
          rx_valid_nxt = rxd_s;
        end else begin
          rx_cnt_nxt = rx_cnt - 1'b1;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  // Holding register between receiver and transmitter. A fresh byte goes
  // straight to an idle transmitter so the echo starts one cycle after
  // rx_valid; otherwise it waits here. A byte arriving while the register
  // is full and the transmitter busy is dropped.
  logic       hold_full;
  logic [7:0] hold_data;
  logic       tx_busy;
  logic       tx_load;
  logic       tx_take_hold;
  logic [7:0] tx_data;

  assign tx_take_hold = hold_full & ~tx_busy;
  assign tx_load      = ~tx_busy & (hold_full | rx_valid);
  assign tx_data      = hold_full ? hold_data : rx_sh;

  always_ff @(posedge clk_12mhz) begin
    if (!reset_n) begin
      led       <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (rx_valid) begin
        led <= rx_sh;
      end
      // The register is being emptied this cycle when tx_take_hold is set,
      // so a byte landing on the same edge can refill it.
      if (rx_valid && (tx_take_hold || (!hold_full && tx_busy))) begin
        hold_full <= 1'b1;
        hold_data <= rx_sh;
      end else if (tx_take_hold) begin
        hold_full <= 1'b0;
      end
    end
  end

  uart_tx #(
    .DIV(DIV)
  ) u_tx (
    .clk_12mhz(clk_12mhz),
    .reset_n  (reset_n),
    .load     (tx_load),
    .data     (tx_data),
    .busy     (tx_busy),
    .txd      (txd)
  );

endmodule

// File: tb/tb_uart_loopback.sv
`timescale 1ns/1ps
module tb_uart_loopback;

  localparam int CLK_FREQUENCY = 12_000_000;
  localparam int BAUD          = 115_200;
  localparam int DIV           = CLK_FREQUENCY / BAUD;
  localparam int HALF          = DIV / 2;
  localparam int FRAME         = 10;
`ifdef RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // edge index (from the first edge that sees the start bit) at which led
  // updates and the echo start bit appears
  localparam int ECHO_LAT = HALF + (FRAME - 1) * DIV + SYNC + 1;

  logic       clk_12mhz = 1'b0;
  logic       reset_n;
  logic       rxd;
  logic       txd;
  logic [7:0] led;

  uart_loopback #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .BAUD         (BAUD)
  ) dut (
    .clk_12mhz(clk_12mhz),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .txd      (txd),
    .led      (led)
  );

  always #42 clk_12mhz = ~clk_12mhz;

  int cyc = 0;
  always @(posedge clk_12mhz) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] exp_led;
  logic [7:0] exp_q[$];

  // txd monitor results
  logic [7:0] got_q[$];
  int         bad_q[$];
  int         st_q[$];

  int         last_e0;
  logic [7:0] led_before, led_after;
  int         first_start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // txd decoder: every bit must hold its level for exactly DIV cycles
  initial begin : monitor
    logic       prev;
    logic       bitv;
    logic [9:0] fr;
    int         bad;
    int         st;
    bit         ab;
    prev = 1'b1;
    forever begin
      @(negedge clk_12mhz);
      if (reset_n === 1'b1 && prev === 1'b1 && txd === 1'b0) begin
        st  = cyc;
        bad = 0;
        ab  = 0;
        fr  = '0;
        for (int k = 0; k < FRAME && !ab; k++) begin
          if (k > 0) @(negedge clk_12mhz);
          bitv = txd;
          for (int j = 0; j < DIV && !ab; j++) begin
            if (j > 0) @(negedge clk_12mhz);
            if (reset_n !== 1'b1) ab = 1;
            else if (txd !== bitv) bad++;
          end
          fr[k] = bitv;
        end
        if (!ab) begin
          if (fr[9] !== 1'b1) bad++;
          got_q.push_back(fr[8:1]);
          bad_q.push_back(bad);
          st_q.push_back(st);
        end
      end
      prev = txd;
    end
  end

  // drives one frame; must be called right after a negedge
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    last_e0 = cyc + 1;
    for (int k = 0; k < FRAME; k++) begin
      rxd = fr[k];
      repeat (DIV) begin
        @(negedge clk_12mhz);
        if (cyc == last_e0 + ECHO_LAT - 1) led_before = led;
        if (cyc == last_e0 + ECHO_LAT) led_after = led;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic good);
    logic [7:0] led_old;
    led_old = exp_led;
    send_frame(b, good);
    if (good) begin
      exp_led = b;
      exp_q.push_back(b);
    end
    chk("led_before", {24'd0, led_before}, {24'd0, led_old});
    chk("led_after", {24'd0, led_after}, {24'd0, exp_led});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  task automatic compare_echo(input bit b2b);
    int n, t, prev_st, st, bad;
    logic [7:0] g, e;
    bit first;
    n = exp_q.size();
    t = 0;
    while (got_q.size() < n && t < 2 * FRAME * DIV * (n + 1)) begin
      @(negedge clk_12mhz);
      t++;
    end
    chk("frame_cnt", got_q.size(), n);
    first = 1;
    prev_st = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g  = got_q.pop_front();
      e  = exp_q.pop_front();
      bad = bad_q.pop_front();
      st = st_q.pop_front();
      chk("echo_byte", {24'd0, g}, {24'd0, e});
      chk("echo_bit_timing", bad, 0);
      if (first) first_start = st;
      else if (b2b) chk("b2b_spacing", st - prev_st, FRAME * DIV + 1);
      first = 0;
      prev_st = st;
    end
    exp_q.delete();
    got_q.delete();
    bad_q.delete();
    st_q.delete();
  endtask

  initial begin
    #(84 * 100000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    logic [7:0] b;
    logic good;
    int gap;

    rxd = 1'b1;
    reset_n = 1'b0;
    exp_led = 8'h00;
    idle(2);

    // reset held for ~8.2 us, then released with an idle line
    viol = 0;
    repeat (98) begin
      @(negedge clk_12mhz);
      if (txd !== 1'b1 || led !== 8'h00) viol++;
    end
    chk("reset_hold", viol, 0);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_led", {24'd0, led}, 32'd0);
    reset_n = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk_12mhz);
      if (txd !== 1'b1 || led !== 8'h00) viol++;
    end
    chk("idle_after_reset", viol, 0);
    compare_echo(0);

    // 0x55: led latency, echo start latency, 104-cycle bits
    rx_frame(8'h55, 1'b1);
    compare_echo(0);
    chk("echo_start", first_start, last_e0 + ECHO_LAT);

    // glitch shorter than half a bit
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    viol = 0;
    repeat (1200) begin
      @(negedge clk_12mhz);
      if (txd !== 1'b1) viol++;
    end
    chk("glitch_txd", viol, 0);
    chk("glitch_led", {24'd0, led}, {24'd0, exp_led});
    compare_echo(0);

    // framing error then a good byte
    rx_frame(8'hA3, 1'b0);
    idle(1200);
    compare_echo(0);
    chk("ferr_led", {24'd0, led}, {24'd0, exp_led});
    rx_frame(8'h3C, 1'b1);
    compare_echo(0);

    // back-to-back frames with no idle gap
    rx_frame(8'h01, 1'b1);
    rx_frame(8'h02, 1'b1);
    rx_frame(8'hFF, 1'b1);
    compare_echo(1);
    chk("b2b_led", {24'd0, led}, 32'hFF);

    // randomized traffic, some with a bad stop bit
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      rx_frame(b, good);
      gap = good ? int'($urandom_range(0, 150)) : int'($urandom_range(80, 200));
      idle(gap);
    end
    compare_echo(0);

    // reset in the middle of an echoed frame
    rx_frame(8'h00, 1'b1);
    idle(400);
    chk("pre_reset_txd", {31'd0, txd}, 32'd0);
    reset_n = 1'b0;
    exp_led = 8'h00;
    exp_q.delete();
    @(negedge clk_12mhz);
    chk("mid_reset_txd", {31'd0, txd}, 32'd1);
    chk("mid_reset_led", {24'd0, led}, 32'd0);
    @(negedge clk_12mhz);
    reset_n = 1'b1;
    idle(1200);
    chk("aborted_frames", got_q.size(), 0);
    got_q.delete();
    bad_q.delete();
    st_q.delete();
    rx_frame(8'h7E, 1'b1);
    compare_echo(0);
    chk("post_reset_start", first_start, last_e0 + ECHO_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
